// File: rtl/clock_divider_pkg.sv
`default_nettype none
// ==========================================================================
// clock_divider_pkg : shared helpers for the programmable clock divider
// Rev 1.0
// ==========================================================================
package clock_divider_pkg;

  localparam int unsigned CFG_CH_W_MIN = 1;

  function automatic int unsigned cfg_ch_w(input int unsigned nch);
    if (nch > 1) return unsigned'($clog2(nch));
    return CFG_CH_W_MIN;
  endfunction

  function automatic int unsigned hi_len(input int unsigned d);
    return (d + 1) / 2;
  endfunction

  function automatic int unsigned rst_div(input int unsigned idx);
    return 32'd2 << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_chan.sv
`default_nettype none
// ==========================================================================
// clock_divider_chan : one divider channel with shadow divisor
// Rev 1.0
// ==========================================================================
module clock_divider_chan
  import clock_divider_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned IDX   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             out_clk_o,
  output logic             tick_o,
  output logic             pending_o
);

  localparam logic [DIV_W-1:0] c_rst_div = DIV_W'(rst_div(IDX));

  logic             run_q,  run_d;
  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [DIV_W-1:0] div_q,  div_d;
  logic [DIV_W-1:0] nxt_q,  nxt_d;
  logic             pend_q, pend_d;
  logic             out_q,  out_d;
  logic             tick_q, tick_d;
  logic             w_boundary;
  logic [DIV_W-1:0] w_div_eff;

  always_comb begin
    run_d      = run_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    nxt_d      = nxt_q;
    pend_d     = pend_q;
    out_d      = out_q;
    tick_d     = 1'b0;
    w_boundary = !run_q || (cnt_q == div_q - 1'b1);
    w_div_eff  = pend_q ? nxt_q : div_q;
    if (w_boundary) begin
      div_d  = w_div_eff;
      pend_d = 1'b0;
      cnt_d  = '0;
      if (en_i && (w_div_eff != '0)) begin
        run_d  = 1'b1;
        out_d  = 1'b1;
        tick_d = 1'b1;
      end else begin
        run_d  = 1'b0;
        out_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
      out_d = (32'(cnt_q) + 32'd1) < hi_len(32'(div_q));
    end
    // A write is only accepted while nothing is pending, so it never collides
    // with the apply above and waits for the following boundary.
    if (wr_i) begin
      nxt_d  = wr_div_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      div_q  <= c_rst_div;
      nxt_q  <= '0;
      pend_q <= 1'b0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      nxt_q  <= nxt_d;
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_clk_o = out_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/clock_divider_prog.sv
`default_nettype none
// ==========================================================================
// clock_divider_prog : NCH-channel run-time programmable clock divider
// Rev 1.0
// ==========================================================================
module clock_divider_prog
  import clock_divider_pkg::*;
#(
  parameter  int unsigned NCH   = 3,
  parameter  int unsigned DIV_W = 8,
  localparam int unsigned CH_W  = cfg_ch_w(NCH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [NCH-1:0]   out_clk,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  if (DIV_W < NCH + 1) begin : g_bad_div_w
    $error("clock_divider_prog: DIV_W must be at least NCH+1");
  end

  logic [NCH-1:0] w_wr;

  // Out-of-range channels match no index: ready stays high, write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    w_wr      = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pending[i];
        w_wr[i]   = cfg_valid && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clock_divider_chan #(
      .DIV_W (DIV_W),
      .IDX   (g)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .en_i      (en[g]),
      .wr_i      (w_wr[g]),
      .wr_div_i  (cfg_div),
      .out_clk_o (out_clk[g]),
      .tick_o    (tick[g]),
      .pending_o (pending[g])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
`default_nettype none
// ==========================================================================
// tb_clock_divider_prog : scoreboard bench against a period-timestamp model
// Rev 1.0
// ==========================================================================
module tb_clock_divider_prog;

  localparam int unsigned NCH   = 3;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CH_W  = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic [NCH-1:0]   en = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [NCH-1:0]   out_clk;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  always #5 clk = ~clk;

  clock_divider_prog #(
    .NCH   (NCH),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .out_clk   (out_clk),
    .tick      (tick),
    .pending   (pending)
  );

  typedef struct packed {
    logic [NCH-1:0] oc;
    logic [NCH-1:0] tk;
    logic [NCH-1:0] pd;
    logic           rdy;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: each running channel remembers the edge its period began; the
  // waveform follows from the distance to that edge.
  bit          m_run  [NCH];
  bit          m_pend [NCH];
  int unsigned m_div  [NCH];
  int unsigned m_nxt  [NCH];
  int unsigned m_start[NCH];
  int unsigned edge_n;

  function automatic int unsigned m_pos(int i);
    return edge_n - m_start[i];
  endfunction

  function automatic bit m_out(int i);
    return m_run[i] && (m_pos(i) < (m_div[i] + 1) / 2);
  endfunction

  function automatic bit m_tick(int i);
    return m_run[i] && (m_pos(i) == 0);
  endfunction

  function automatic bit m_ready();
    if (int'(cfg_ch) < NCH) return !m_pend[cfg_ch];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i]   = 1'b0;
      m_pend[i]  = 1'b0;
      m_div[i]   = 2 << i;
      m_nxt[i]   = 0;
      m_start[i] = 0;
    end
    edge_n = 0;
  endtask

  task automatic step(output bit acc);
    bit bnd[NCH];
    acc = cfg_valid && m_ready();
    for (int i = 0; i < NCH; i++)
      bnd[i] = !m_run[i] || (m_pos(i) == m_div[i] - 1);
    edge_n++;
    for (int i = 0; i < NCH; i++) begin
      if (bnd[i]) begin
        if (m_pend[i]) begin
          m_div[i]  = m_nxt[i];
          m_pend[i] = 1'b0;
        end
        if (en[i] && m_div[i] != 0) begin
          m_run[i]   = 1'b1;
          m_start[i] = edge_n;
        end else begin
          m_run[i] = 1'b0;
        end
      end
    end
    if (acc) begin
      m_nxt[cfg_ch]  = int'(cfg_div);
      m_pend[cfg_ch] = 1'b1;
    end
  endtask

  task automatic check_vec(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
  endtask

  // Called at posedge+2 with inputs already driven; returns with the model
  // advanced by one edge and time at the next posedge+2.
  task automatic cycle(output bit acc);
    exp_t e;
    for (int i = 0; i < NCH; i++) begin
      e.oc[i] = m_out(i);
      e.tk[i] = m_tick(i);
      e.pd[i] = m_pend[i];
    end
    e.rdy = m_ready();
    sb_q.push_back(e);
    @(posedge clk);
    step(acc);
    #2;
  endtask

  task automatic async_reset(input string nm);
    #1 reset_n = 1'b0;
    #1;
    check_vec({nm, "_outputs"}, 32'({out_clk, tick, pending}), 32'd0);
    check_vec({nm, "_ready"}, 32'(cfg_ready), 32'd1);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_checks++;
        if ({out_clk, tick, pending, cfg_ready} === e) n_pass++;
        else $display("FAIL scoreboard t=%0t actual oc=%b tk=%b pd=%b rdy=%b expected oc=%b tk=%b pd=%b rdy=%b",
                      $time, out_clk, tick, pending, cfg_ready, e.oc, e.tk, e.pd, e.rdy);
      end
    end
  end

  initial begin : stim
    bit acc;
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check_vec("reset_outputs", 32'({out_clk, tick, pending}), 32'd0);
    check_vec("reset_ready", 32'(cfg_ready), 32'd1);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    en = 3'b111;
    repeat (24) cycle(acc);

    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5;
    cycle(acc);
    cfg_ch = 2'd2; cfg_div = 8'd8;
    cycle(acc);
    cfg_ch = 2'd0; cfg_div = 8'd3; acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(acc);
    cfg_valid = 1'b0;
    repeat (16) cycle(acc);

    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd1; acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(acc);
    cfg_valid = 1'b0;
    repeat (12) cycle(acc);
    cfg_valid = 1'b1; cfg_div = 8'd0; acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(acc);
    cfg_valid = 1'b0;
    repeat (12) cycle(acc);
    cfg_valid = 1'b1; cfg_div = 8'd4; acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) cycle(acc);
    cfg_valid = 1'b0;
    repeat (8) cycle(acc);

    for (int k = 0; k < 16 && !(m_run[2] && m_pos(2) == 1); k++) cycle(acc);
    en[2] = 1'b0;
    repeat (20) cycle(acc);
    en[2] = 1'b1;
    repeat (10) cycle(acc);

    for (int k = 0; k < 20 && !(m_out(2) && m_pos(2) > 0); k++) cycle(acc);
    async_reset("async_reset_high");
    repeat (20) cycle(acc);

    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 31) == 0) en[i] = ~en[i];
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CH_W'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 7) == 0) ? DIV_W'($urandom_range(0, 40))
                                             : DIV_W'($urandom_range(0, 12));
      if (n == 750) async_reset("async_reset_rand");
      cycle(acc);
    end
    cfg_valid = 1'b0;

    repeat (2) @(negedge clk);
    check_vec("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clock_divider_prog.md
# clock_divider_prog

Parametrised, multi-channel successor to the fixed /2, /4, /8 clock divider. Each of `NCH` channels divides `clk` by a run-time programmable integer, produces a registered near-50 %-duty divided clock plus a one-cycle period tick, and changes ratio or stops only at a period boundary so no runt pulse is ever emitted. It sits next to the clock/reset logic and feeds slow strobes and derived clocks to downstream blocks.

## Interface
- `NCH`, default 3: number of independent channels; 1 or more.
- `DIV_W`, default 8: divisor width; elaboration error if `DIV_W < NCH+1`.
- `clk`  in  1  sole clock; all flops on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  NCH  per-channel run enable.
- `cfg_valid`  in  1  divisor write request.
- `cfg_ready`  out  1  write accepted this cycle when high together with `cfg_valid`.
- `cfg_ch`  in  $clog2(NCH) (min 1)  target channel.
- `cfg_div`  in  DIV_W  new divisor D; 0 means stop.
- `out_clk`  out  NCH  divided clock per channel.
- `tick`  out  NCH  one-cycle pulse on the cycle `out_clk` rises (period start).
- `pending`  out  NCH  channel holds an accepted divisor not yet applied.

## Operation
- Per channel state: `run`, `cnt` (DIV_W bits, 0..D-1), active divisor `div`, shadow `nxt_div`, `pending`.
- Reset values: `div` of channel i = 2<<i (reproduces /2, /4, /8 with defaults); `cnt`=0, `run`=0, `pending`=0, `out_clk`=0, `tick`=0.
- High-phase length H = ceil(D/2); low-phase = floor(D/2). D=1: `out_clk` constant 1, `tick` every cycle.
- Boundary = channel not running, or running with `cnt == div-1`.
- At each edge, in a channel at a boundary: if `pending`, `div <= nxt_div` and clear `pending`; then with the resulting divisor Dn, if `en` and Dn != 0: `run<=1`, `cnt<=0`, `out_clk<=1`, `tick<=1`; else `run<=0`, `cnt<=0`, `out_clk<=0`, `tick<=0`.
- Not at a boundary: `cnt<=cnt+1`; `out_clk <= (cnt+1 < H)`; `tick<=0`. `en` falling mid-period is ignored until the boundary; the last period completes in full.
- Config handshake: `cfg_ready = !pending[cfg_ch]` for in-range `cfg_ch`; out-of-range `cfg_ch` gives `cfg_ready=1` and the write is dropped. Transfer (`cfg_valid && cfg_ready`) loads `nxt_div` and sets `pending` on that edge.
- A transfer on the same edge as a boundary is not applied at that boundary; it waits for the next one (for an idle channel: the following edge).
- D=0 stops the channel low at its next boundary; it restarts only after a nonzero divisor is applied and `en` is high.
- Channels are fully independent; simultaneous boundaries on several channels need no arbitration.

## Timing
- Start latency: `en` high sampled at edge k on an idle channel -> `out_clk`=1, `tick`=1 after edge k.
- Steady state: `out_clk` period exactly D cycles, `tick` exactly once per period.
- Ratio-change latency: at most one full current period plus one cycle after the transfer.
- `reset_n` assertion clears every output immediately, regardless of `clk`; deassertion is synchronised externally.
- All outputs registered; `cfg_ready` is combinational from `pending` and `cfg_ch` only.

## Structure
- Package `clock_divider_pkg`: function `hi_len(D)` = ceil(D/2), function `rst_div(i)` = 2<<i, localparam for `cfg_ch` width.
- Sub-module `clock_divider_chan`: one channel (counter, shadow divisor, pending, output regs), instantiated `NCH` times in a generate loop; top contains only `cfg_ready` decode and write fan-out.

## Test plan
- Reset, `en`=3'b111, defaults -> `out_clk` periods 2, 4, 8 cycles; ch1 sequence 1,1,0,0 repeating; `tick` at each rise.
- Ch0 write D=5 mid-period -> `pending[0]`=1 until boundary, then pattern 1,1,1,0,0; no high pulse shorter than 2 cycles during switch.
- Second write to ch0 while `pending[0]`=1 -> `cfg_ready`=0, held valid accepted the cycle after apply; writes to ch2 accepted meanwhile.
- D=1 on ch1 -> `out_clk[1]` stays 1, `tick[1]` every cycle; then D=0 -> channel low, `tick` stops at next boundary.
- Drop `en[2]` on cycle 2 of a D=8 period -> period completes (4 high, 4 low), then stays low; re-raise -> rises next edge.
- Assert `reset_n`=0 mid-high-phase between clock edges -> all outputs 0 immediately, divisors back to 2/4/8.
